// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the core/memory arbiter.
// Size codes, state encodings and the memory request bundle.
package mem_arbiter_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef enum logic {
    PASS   = 1'b0,
    SECOND = 1'b1
  } arb_state_t;

  // ram=1 marks a data-port request, ram=0 a fetch.
  typedef struct packed {
    logic        ram;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Merges core fetch and data ports onto one single-port memory.
// Ports: clk/rst_n, i_en->o_core_en, i_rom_*/o_rom_data fetch,
// i_ram_*/o_ram_rdata data, o_mem_*/i_mem_rdata memory,
// o_conflict_cnt saturating stall count.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit DATA_FIRST = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic             o_core_en,
  input  logic             i_rom_en,
  input  logic [31:0]      i_rom_addr,
  output logic [31:0]      o_rom_data,
  input  logic             i_ram_en,
  input  logic             i_ram_wr,
  input  logic [1:0]       i_ram_size,
  input  logic [31:0]      i_ram_addr,
  input  logic [31:0]      i_ram_wdata,
  output logic [31:0]      o_ram_rdata,
  output logic             o_mem_en,
  output logic             o_mem_wr,
  output logic [1:0]       o_mem_size,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  input  logic [31:0]      i_mem_rdata,
  output logic [CNT_W-1:0] o_conflict_cnt
);

  arb_state_t       state;
  mem_req_t         pend;
  mem_req_t         rom_req;
  mem_req_t         ram_req;
  mem_req_t         iss;
  mem_req_t         lose;
  logic             iss_en;
  logic             rom_acc;
  logic             ram_acc;
  logic             both;
  logic             rd_vld;
  logic             rd_ram;
  logic [31:0]      rom_hold;
  logic [31:0]      ram_hold;
  logic [CNT_W-1:0] cnt;

  assign o_core_en = i_en & (state == PASS);

  // rst_n gating keeps the memory idle while reset is held.
  assign rom_acc = rst_n & o_core_en & i_rom_en;
  assign ram_acc = rst_n & o_core_en & i_ram_en;
  assign both    = rom_acc & ram_acc;

  assign rom_req = '{ram: 1'b0, wr: 1'b0, size: MEM_W,
                     addr: i_rom_addr, wdata: 32'h0};
  assign ram_req = '{ram: 1'b1, wr: i_ram_wr,
                     size: i_ram_size, addr: i_ram_addr,
                     wdata: i_ram_wdata};

  // Core requests are never accepted in SECOND,
  // so these selections are mutually exclusive.
  always_comb begin
    iss    = '0;
    lose   = rom_req;
    iss_en = 1'b0;
    unique case (1'b1)
      (state == SECOND): begin
        iss    = pend;
        iss_en = 1'b1;
      end
      both: begin
        iss    = DATA_FIRST ? ram_req : rom_req;
        lose   = DATA_FIRST ? rom_req : ram_req;
        iss_en = 1'b1;
      end
      (ram_acc & ~rom_acc): begin
        iss    = ram_req;
        iss_en = 1'b1;
      end
      (rom_acc & ~ram_acc): begin
        iss    = rom_req;
        iss_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_mem_en    = iss_en;
  assign o_mem_wr    = iss_en & iss.wr;
  assign o_mem_size  = iss.size;
  assign o_mem_addr  = iss.addr;
  assign o_mem_wdata = iss.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PASS;
      pend     <= '0;
      rd_vld   <= 1'b0;
      rd_ram   <= 1'b0;
      rom_hold <= 32'h0;
      ram_hold <= 32'h0;
      cnt      <= '0;
    end else begin
      state  <= both ? SECOND : PASS;
      rd_vld <= iss_en & ~iss.wr;
      rd_ram <= iss.ram;
      if (both) begin
        pend <= lose;
        if (cnt != '1)
          cnt <= cnt + 1'b1;
      end
      if (rd_vld & rd_ram)
        ram_hold <= i_mem_rdata;
      if (rd_vld & ~rd_ram)
        rom_hold <= i_mem_rdata;
    end
  end

  assign o_rom_data  = (rd_vld & ~rd_ram) ? i_mem_rdata
                                           : rom_hold;
  assign o_ram_rdata = (rd_vld &  rd_ram) ? i_mem_rdata
                                           : ram_hold;
  assign o_conflict_cnt = cnt;

endmodule
